// File: rtl/cache_types_pkg.sv
// Shared cache geometry and state types for the line/burst adaptor and cache datapath.
package cache_types_pkg;

    localparam int s_line   = 256;
    localparam int s_burst  = 64;
    localparam int s_offset = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } cba_state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:s_offset], {s_offset{1'b0}}};
    endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Splits a one-shot cache line read/write into a num_beats x s_burst memory burst.
// Request sampled in IDLE, beats follow mem_resp (gaps stall), one-cycle line_resp after the last beat.
module cacheline_burst_adaptor
    import cache_types_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         line_address,
    input  logic                line_read,
    input  logic                line_write,
    input  logic [s_line-1:0]   line_wdata,
    output logic [s_line-1:0]   line_rdata,
    output logic                line_resp,
    output logic [31:0]         mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [s_burst-1:0]  mem_wdata,
    input  logic [s_burst-1:0]  mem_rdata,
    input  logic                mem_resp
);

    localparam int num_beats = s_line / s_burst;
    localparam int beat_w    = $clog2(num_beats);
    localparam logic [beat_w-1:0] last_beat = beat_w'(num_beats - 1);

    cba_state_t                          state_q, state_d;
    logic [beat_w-1:0]                   beat_q, beat_d;
    logic [31:0]                         addr_q, addr_d;
    logic [num_beats-1:0][s_burst-1:0]   wbuf_q, wbuf_d;
    logic [num_beats-1:0][s_burst-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        rdata_d   = rdata_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_wdata = '0;
        line_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins when both requests are raised together.
                if (line_write) begin
                    wbuf_d  = line_wdata;
                    addr_d  = line_align(line_address);
                    state_d = WRITE;
                end else if (line_read) begin
                    addr_d  = line_align(line_address);
                    state_d = READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    rdata_d[beat_q] = mem_rdata;
                    beat_d          = beat_q + 1'b1;
                    if (beat_q == last_beat) state_d = DONE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_wdata = wbuf_q[beat_q];
                if (mem_resp) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == last_beat) state_d = DONE;
                end
            end
            DONE: begin
                line_resp = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign line_rdata  = rdata_q;
    assign mem_address = addr_q;

endmodule
